counter_checker: RTL and testbench

Receive-side companion to the free-running counter: consumes a counter value stream, qualified by a valid strobe, and checks that each sample is exactly the previous one plus one, modulo 2^WIDTH. It hunts for the sequence and declares lock after a run of correct samples. Once locked, it flags and counts mismatches, and drops lock after repeated consecutive misses. It sits on the sink side of any counter-driven datapath in bring-up and self-test configurations.

---
 rtl/counter_checker_pkg.sv | 22 ++
 rtl/counter_checker_sat_counter.sv | 44 ++++
 rtl/counter_checker.sv | 165 ++++++++++++++++
 tb/tb_counter_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg
// Shared types and default parameters for the counter sequence checker.
//   state_e              : checker state (HUNT, VERIFY, LOCKED, SLIP)
//   DEFAULT_WIDTH        : width of the counter value under check
//   DEFAULT_LOCK_THRESH  : correct increments after the seed needed to lock
//   DEFAULT_LOSS_THRESH  : consecutive misses while locked that drop lock
//   DEFAULT_CNT_WIDTH    : width of the saturating error counter
package counter_checker_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_LOCK_THRESH = 4;
  localparam int DEFAULT_LOSS_THRESH = 2;
  localparam int DEFAULT_CNT_WIDTH   = 16;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear. Clear wins over increment.
// Once the count reaches all-ones it holds there until cleared.
//   i_clk      : clock, rising edge
//   i_reset_n  : asynchronous active-low reset, count returns to 0
//   i_clear    : synchronous clear to 0
//   i_inc      : increment by one this cycle (ignored when saturated)
//   o_count    : registered count value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc && (count_q != ALL_ONE)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/counter_checker.sv
// counter_checker
// Receive-side checker for a free-running counter stream. Each valid sample
// must equal the previous sample plus one (mod 2^WIDTH). The checker hunts for
// the sequence, locks after a run of correct increments, then flags and counts
// mismatches, dropping lock after LOSS_THRESHOLD consecutive misses.
//   i_clk          : clock, all state on rising edge
//   i_reset_n      : asynchronous active-low reset
//   i_clear        : synchronous clear (error count to 0, back to HUNT)
//   i_valid        : i_value carries a sample this cycle
//   i_value        : counter value under check
//   o_locked       : high in LOCKED and SLIP
//   o_error        : one-cycle pulse per counted mismatch
//   o_error_count  : saturating mismatch count
//   o_expected     : value expected on the next valid sample
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int LOCK_THRESHOLD = DEFAULT_LOCK_THRESH,
  parameter int LOSS_THRESHOLD = DEFAULT_LOSS_THRESH,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_value,
  output logic                 o_locked,
  output logic                 o_error,
  output logic [CNT_WIDTH-1:0] o_error_count,
  output logic [WIDTH-1:0]     o_expected
);

  localparam int RUN_W  = $clog2(LOCK_THRESHOLD + 1);
  localparam int MISS_W = $clog2(LOSS_THRESHOLD + 1);

  localparam logic [WIDTH-1:0]  VAL_ONE   = WIDTH'(1);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_THRESHOLD);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_THRESHOLD);

  state_e            state_q,    state_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic [RUN_W-1:0]  run_q,      run_d;
  logic [MISS_W-1:0] miss_q,     miss_d;
  logic              locked_q,   locked_d;
  logic              error_q,    error_d;

  logic              match;
  logic [RUN_W-1:0]  run_next;
  logic [MISS_W-1:0] miss_next;

  assign match     = (i_value == expected_q);
  assign run_next  = run_q + RUN_ONE;
  assign miss_next = miss_q + MISS_ONE;

  // Once locked the expected value keeps advancing on every sample, right or
  // wrong (flywheel), so a single corrupted sample does not desynchronise us.
  // Before lock a mismatch simply re-seeds from the sample just seen.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    run_d      = run_q;
    miss_d     = miss_q;
    error_d    = 1'b0;

    if (i_clear) begin
      state_d = HUNT;
      run_d   = '0;
      miss_d  = '0;
    end else if (i_valid) begin
      unique case (state_q)
        HUNT: begin
          expected_d = i_value + VAL_ONE;
          run_d      = '0;
          state_d    = VERIFY;
        end

        VERIFY: begin
          if (match) begin
            expected_d = expected_q + VAL_ONE;
            run_d      = run_next;
            if (run_next == RUN_LOCK) begin
              state_d = LOCKED;
              run_d   = '0;
            end
          end else begin
            expected_d = i_value + VAL_ONE;
            run_d      = '0;
          end
        end

        LOCKED: begin
          expected_d = expected_q + VAL_ONE;
          if (!match) begin
            error_d = 1'b1;
            if (LOSS_THRESHOLD == 1) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              state_d = SLIP;
              miss_d  = MISS_ONE;
            end
          end
        end

        SLIP: begin
          expected_d = expected_q + VAL_ONE;
          if (match) begin
            miss_d  = '0;
            state_d = LOCKED;
          end else begin
            error_d = 1'b1;
            if (miss_next == MISS_LOSS) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_next;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED) || (state_d == SLIP);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= HUNT;
      expected_q <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_error_count (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_inc     (error_d),
    .o_count   (o_error_count)
  );

  assign o_locked   = locked_q;
  assign o_error    = error_q;
  assign o_expected = expected_q;

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker
// Drives sample streams into counter_checker (CNT_WIDTH=2 so saturation is
// reachable) and compares every registered output against an independent
// behavioural reference through a scoreboard queue, plus directed checks.
module tb_counter_checker;

  localparam int W    = 16;
  localparam int LOCK = 4;
  localparam int LOSS = 2;
  localparam int CW   = 2;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic          valid;
  logic [W-1:0]  value;
  logic          locked;
  logic          error;
  logic [CW-1:0] error_count;
  logic [W-1:0]  expected;

  counter_checker #(
    .WIDTH          (W),
    .LOCK_THRESHOLD (LOCK),
    .LOSS_THRESHOLD (LOSS),
    .CNT_WIDTH      (CW)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_clear       (clear),
    .i_valid       (valid),
    .i_value       (value),
    .o_locked      (locked),
    .o_error       (error),
    .o_error_count (error_count),
    .o_expected    (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          locked;
    logic          err;
    logic [CW-1:0] cnt;
    logic [W-1:0]  exp;
    bit            chk_exp;
    string         tag;
  } expect_t;

  expect_t sb_q[$];

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model state: 0=hunt 1=verify 2=locked 3=slip
  int            m_state;
  int            m_run;
  int            m_miss;
  logic [W-1:0]  m_exp;
  logic [CW-1:0] m_cnt;
  logic          m_err;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, required);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_run   = 0;
    m_miss  = 0;
    m_exp   = '0;
    m_cnt   = '0;
    m_err   = 1'b0;
  endtask

  task automatic modelBump();
    m_err = 1'b1;
    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic modelStep(input bit v, input logic [W-1:0] val, input bit clr);
    m_err = 1'b0;
    if (clr) begin
      m_state = 0;
      m_cnt   = '0;
      m_run   = 0;
      m_miss  = 0;
    end else if (v) begin
      case (m_state)
        0: begin
          m_exp   = val + 16'd1;
          m_run   = 0;
          m_state = 1;
        end
        1: begin
          if (val == m_exp) begin
            m_exp = m_exp + 16'd1;
            m_run++;
            if (m_run == LOCK) m_state = 2;
          end else begin
            m_exp = val + 16'd1;
            m_run = 0;
          end
        end
        2: begin
          if (val != m_exp) begin
            modelBump();
            m_miss  = 1;
            m_state = (LOSS == 1) ? 0 : 3;
          end
          m_exp = m_exp + 16'd1;
        end
        default: begin
          if (val == m_exp) begin
            m_miss  = 0;
            m_state = 2;
          end else begin
            modelBump();
            m_miss++;
            if (m_miss == LOSS) m_state = 0;
          end
          m_exp = m_exp + 16'd1;
        end
      endcase
    end
  endtask

  // Drive one cycle of stimulus, push the reference outcome, then pop and
  // compare once the DUT has registered the sample.
  task automatic applyStimulus(input bit v, input logic [W-1:0] val, input bit clr, input string tag);
    expect_t e;
    expect_t got;
    @(negedge clk);
    valid = v;
    value = val;
    clear = clr;
    modelStep(v, val, clr);
    e.locked  = (m_state == 2) || (m_state == 3);
    e.err     = m_err;
    e.cnt     = m_cnt;
    e.exp     = m_exp;
    e.chk_exp = !clr;
    e.tag     = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checkOutput({got.tag, ".locked"}, 32'(locked), 32'(got.locked));
    checkOutput({got.tag, ".error"}, 32'(error), 32'(got.err));
    checkOutput({got.tag, ".count"}, 32'(error_count), 32'(got.cnt));
    if (got.chk_exp) checkOutput({got.tag, ".expected"}, 32'(expected), 32'(got.exp));
  endtask

  task automatic lockAt(input logic [W-1:0] start, input string tag);
    applyStimulus(1'b0, '0, 1'b1, {tag, "_clr"});
    for (int i = 0; i <= LOCK; i++) applyStimulus(1'b1, start + W'(i), 1'b0, tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".locked"}, 32'(locked), 32'd0);
    checkOutput({tag, ".error"}, 32'(error), 32'd0);
    checkOutput({tag, ".count"}, 32'(error_count), 32'd0);
    checkOutput({tag, ".expected"}, 32'(expected), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    valid   = 1'b0;
    value   = '0;
    modelReset();
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Lock on 0..4
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, W'(i), 1'b0, "lock");
      if (i == 3) checkOutput("lock_pre", 32'(locked), 32'd0);
    end
    checkOutput("lock_up", 32'(locked), 32'd1);
    checkOutput("lock_exp", 32'(expected), 32'd5);
    checkOutput("lock_cnt", 32'(error_count), 32'd0);

    // Gaps change nothing
    applyStimulus(1'b0, 16'h1234, 1'b0, "gap");
    applyStimulus(1'b0, 16'h0000, 1'b0, "gap");
    checkOutput("gap_exp", 32'(expected), 32'd5);

    // Wrap through 0xFFFF
    lockAt(16'hFFFA, "wrap_lock");
    applyStimulus(1'b1, 16'hFFFF, 1'b0, "wrap");
    applyStimulus(1'b1, 16'h0000, 1'b0, "wrap");
    applyStimulus(1'b1, 16'h0001, 1'b0, "wrap");
    checkOutput("wrap_locked", 32'(locked), 32'd1);
    checkOutput("wrap_exp", 32'(expected), 32'h0002);
    checkOutput("wrap_err", 32'(error_count), 32'd0);

    // Single miss: SLIP then back to LOCKED
    lockAt(16'd5, "slip_lock");
    applyStimulus(1'b1, 16'd10, 1'b0, "slip");
    applyStimulus(1'b1, 16'd99, 1'b0, "slip");
    checkOutput("slip_pulse", 32'(error), 32'd1);
    checkOutput("slip_cnt", 32'(error_count), 32'd1);
    checkOutput("slip_held", 32'(locked), 32'd1);
    applyStimulus(1'b1, 16'd12, 1'b0, "slip");
    checkOutput("slip_relock", 32'(locked), 32'd1);

    // Held value twice drops lock, next sample seeds
    lockAt(16'd15, "loss_lock");
    applyStimulus(1'b1, 16'd7, 1'b0, "loss");
    applyStimulus(1'b1, 16'd7, 1'b0, "loss");
    checkOutput("loss_cnt", 32'(error_count), 32'd2);
    checkOutput("loss_unlock", 32'(locked), 32'd0);
    applyStimulus(1'b1, 16'd30, 1'b0, "loss_seed");
    checkOutput("loss_seed_exp", 32'(expected), 32'd31);

    // Re-seed during VERIFY
    applyStimulus(1'b0, '0, 1'b1, "reseed_clr");
    applyStimulus(1'b1, 16'd0, 1'b0, "reseed");
    applyStimulus(1'b1, 16'd1, 1'b0, "reseed");
    for (int v = 5; v <= 9; v++) applyStimulus(1'b1, W'(v), 1'b0, "reseed");
    checkOutput("reseed_locked", 32'(locked), 32'd1);
    checkOutput("reseed_cnt", 32'(error_count), 32'd0);

    // Four isolated misses saturate the 2-bit count at 3
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 16'hBEEF, 1'b0, "sat_miss");
      applyStimulus(1'b1, m_exp, 1'b0, "sat_match");
    end
    checkOutput("sat_cnt", 32'(error_count), 32'd3);
    applyStimulus(1'b1, m_exp, 1'b1, "sat_clear");
    checkOutput("clear_cnt", 32'(error_count), 32'd0);
    checkOutput("clear_locked", 32'(locked), 32'd0);
    applyStimulus(1'b1, 16'd100, 1'b0, "clear_seed");
    checkOutput("clear_seed_exp", 32'(expected), 32'd101);

    // Random matching stream with occasional gaps keeps lock
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, W'($urandom), 1'b0, "rand_gap");
      else applyStimulus(1'b1, m_exp, 1'b0, "rand");
    end

    // Asynchronous reset mid-lock discards history
    lockAt(16'd40, "rst_lock");
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkResetOutputs("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 16'd200, 1'b0, "post_reset_seed");
    checkOutput("post_reset_exp", 32'(expected), 32'd201);

    applyStimulus(1'b0, '0, 1'b0, "idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
